spm_bus_if: RTL and testbench

- Per-stage memory access front end; one instance in IF (instruction fetch), one in MEM (load/store).
- Decodes the stage's word address. Accesses to the SPM region drive the matching SPM port of the dual-port scratchpad directly and complete with zero wait.
- All other accesses arbitrate for the shared system bus through a request/grant/ready handshake. The pipeline is stalled via `busy` until the bus access completes.

---
 rtl/spm_bus_if.sv | 161 ++++++++++++++++
 tb/tb_spm_bus_if.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spm_bus_if.sv
// spm_bus_if: per-stage memory access front end (IF or MEM stage).
// Word accesses whose addr[29:27] matches SPM_REGION go straight to one port
// of the dual-port scratchpad with zero wait. Every other access requests the
// shared system bus, and the stage is held with busy until ready returns.
// Optional feature macro: SPM_BUS_IF_TIMEOUT_EN. When it is defined, an access
// that has no ready after TIMEOUT_CYC cycles is aborted and bus_err pulses.
module spm_bus_if #(
  parameter logic [2:0] SPM_REGION  = 3'd1,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [11:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        bus_err
);

  localparam logic READ = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t      state, state_nx;
  logic [31:0] rd_buf, rd_buf_nx;
  logic        bus_req_nx, bus_as_nx, bus_rw_nx;
  logic [29:0] bus_addr_nx;
  logic [31:0] bus_wr_data_nx;
  logic        spm_sel, bus_start, timeout;

`ifdef SPM_BUS_IF_TIMEOUT_EN
  logic [7:0]  cnt, cnt_nx;

  // Abort only when the limit is reached and ready is still absent.
  assign timeout = (state == ACCESS) && bus_rdy_ && (cnt == TIMEOUT_CYC);
  assign bus_err = timeout;

  // Cycle counter for the current bus access.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt <= '0;
    else         cnt <= cnt_nx;
  end
`else
  logic        unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign bus_err            = 1'b0;
`endif

  assign spm_sel   = (state == IDLE) && !flush && !as_ && (addr[29:27] == SPM_REGION);
  assign bus_start = (state == IDLE) && !flush && !as_ && (addr[29:27] != SPM_REGION);

  assign spm_addr    = addr[11:0];
  assign spm_as_     = !spm_sel;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  // State and registered bus-side outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      rd_buf      <= '0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_addr    <= '0;
      bus_rw      <= READ;
      bus_wr_data <= '0;
    end else begin
      state       <= state_nx;
      rd_buf      <= rd_buf_nx;
      bus_req_    <= bus_req_nx;
      bus_as_     <= bus_as_nx;
      bus_addr    <= bus_addr_nx;
      bus_rw      <= bus_rw_nx;
      bus_wr_data <= bus_wr_data_nx;
    end
  end

  // Next-state logic and stage-side outputs.
  always_comb begin
    state_nx       = state;
    rd_buf_nx      = rd_buf;
    bus_req_nx     = bus_req_;
    bus_as_nx      = bus_as_;
    bus_addr_nx    = bus_addr;
    bus_rw_nx      = bus_rw;
    bus_wr_data_nx = bus_wr_data;
    busy           = 1'b0;
    rd_data        = '0;
`ifdef SPM_BUS_IF_TIMEOUT_EN
    cnt_nx         = cnt;
`endif
    case (state)
      IDLE: begin
        if (spm_sel) rd_data = spm_rd_data;
        if (bus_start) begin
          bus_addr_nx    = addr;
          bus_rw_nx      = rw;
          bus_wr_data_nx = wr_data;
          bus_req_nx     = 1'b0;
          state_nx       = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (!bus_grnt_) begin
          bus_as_nx = 1'b0;
          state_nx  = ACCESS;
`ifdef SPM_BUS_IF_TIMEOUT_EN
          cnt_nx    = '0;
`endif
        end
      end
      ACCESS: begin
        bus_as_nx = 1'b1;
        if (!bus_rdy_) begin
          rd_data        = bus_rd_data;
          bus_req_nx     = 1'b1;
          bus_addr_nx    = '0;
          bus_rw_nx      = READ;
          bus_wr_data_nx = '0;
          if (bus_rw == READ) rd_buf_nx = bus_rd_data;
          state_nx       = stall ? STALL : IDLE;
        end else if (timeout) begin
          bus_req_nx = 1'b1;
          rd_buf_nx  = '0;
          state_nx   = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
`ifdef SPM_BUS_IF_TIMEOUT_EN
          cnt_nx = cnt + 8'd1;
`endif
        end
      end
      STALL: begin
        rd_data = rd_buf;
        if (!stall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_bus_if.sv
// Self-checking bench for spm_bus_if: table-driven IDLE/SPM vectors, then
// hand-written bus sequences whose expected transactions go through a queue.
module tb_spm_bus_if;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data;
  logic        busy;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data, spm_rd_data;
  logic        bus_req_, bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_rdy_, bus_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_rd_buf = '0;

  typedef struct {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_txn_t;

  bus_txn_t sb[$];

  typedef struct {
    logic [29:0] addr;
    logic        as_n;
    logic        rw;
    logic        flush;
    logic [31:0] wdata;
    logic [31:0] spm_rd;
    logic        exp_spm_as_;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  spm_bus_if #(.SPM_REGION(3'd1), .TIMEOUT_CYC(8'd4)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one bus access; entered and left at posedge+1 with the DUT in IDLE.
  task automatic bus_txn(input logic [29:0] a, input logic r, input logic [31:0] wd,
                         input logic [31:0] rdv, input int unsigned gd,
                         input int unsigned rdy_d, input int unsigned st,
                         input logic flush_mid);
    bus_txn_t t;
    t.addr = a; t.rw = r; t.wdata = wd; t.rdata = rdv;
    sb.push_back(t);
    addr = a; rw = r; wr_data = wd; as_ = 1'b0; flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_spm_as", {31'b0, spm_as_}, 32'd1);
    @(posedge clk); #1;
    as_ = 1'b1; addr = 30'h3FFF_FFFF; wr_data = 32'hFFFF_FFFF; rw = ~r;
    if (flush_mid) flush = 1'b1;
    chk("req_bus_req", {31'b0, bus_req_}, 32'd0);
    for (int unsigned i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("req_busy", {31'b0, busy}, 32'd1);
      chk("req_rd", rd_data, 32'd0);
      @(posedge clk); #1;
      chk("req_no_as", {31'b0, bus_as_}, 32'd1);
    end
    bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    bus_grnt_ = 1'b1;
    chk("acc_as_low", {31'b0, bus_as_}, 32'd0);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      t = sb.pop_front();
      chk("acc_addr", {2'b0, bus_addr}, {2'b0, t.addr});
      chk("acc_rw", {31'b0, bus_rw}, {31'b0, t.rw});
      chk("acc_wdata", bus_wr_data, t.wdata);
    end
    for (int unsigned i = 0; i < rdy_d; i++) begin
      @(negedge clk);
      chk("acc_busy", {31'b0, busy}, 32'd1);
      chk("acc_err", {31'b0, bus_err}, 32'd0);
      @(posedge clk); #1;
      chk("acc_as_high", {31'b0, bus_as_}, 32'd1);
    end
    bus_rdy_ = 1'b0; bus_rd_data = t.rdata; flush = 1'b0; stall = (st > 0);
    @(negedge clk);
    chk("rdy_busy", {31'b0, busy}, 32'd0);
    chk("rdy_rd", rd_data, t.rdata);
    if (t.rw) exp_rd_buf = t.rdata;
    @(posedge clk); #1;
    bus_rdy_ = 1'b1; bus_rd_data = 32'hBAD0_BAD0;
    chk("done_req", {31'b0, bus_req_}, 32'd1);
    chk("done_addr", {2'b0, bus_addr}, 32'd0);
    chk("done_rw", {31'b0, bus_rw}, 32'd1);
    chk("done_wdata", bus_wr_data, 32'd0);
    for (int unsigned i = 0; i < st; i++) begin
      if (i == st - 1) stall = 1'b0;
      @(negedge clk);
      chk("stall_busy", {31'b0, busy}, 32'd0);
      chk("stall_rd", rd_data, exp_rd_buf);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("back_idle_busy", {31'b0, busy}, 32'd0);
    chk("back_idle_rd", rd_data, 32'd0);
    chk("back_idle_req", {31'b0, bus_req_}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{30'h0800_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{30'h0800_0004, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[2] = '{30'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0000_0000};
    vecs[3] = '{30'h0800_0010, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h2222_2222, 1'b1, 32'h0000_0000};
    vecs[4] = '{30'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h8765_4321, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA};
    vecs[5] = '{30'h3800_0000, 1'b0, 1'b0, 1'b1, 32'h0F0F_0F0F, 32'h3333_3333, 1'b1, 32'h0000_0000};

    reset_ = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    #12;
    chk("rst_req", {31'b0, bus_req_}, 32'd1);
    chk("rst_as", {31'b0, bus_as_}, 32'd1);
    chk("rst_addr", {2'b0, bus_addr}, 32'd0);
    chk("rst_rw", {31'b0, bus_rw}, 32'd1);
    chk("rst_wdata", bus_wr_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(posedge clk); #1;

    for (int unsigned k = 0; k < 6; k++) begin
      addr = vecs[k].addr; as_ = vecs[k].as_n; rw = vecs[k].rw;
      flush = vecs[k].flush; wr_data = vecs[k].wdata; spm_rd_data = vecs[k].spm_rd;
      @(negedge clk);
      chk("vec_spm_as", {31'b0, spm_as_}, {31'b0, vecs[k].exp_spm_as_});
      chk("vec_spm_addr", {20'b0, spm_addr}, {20'b0, vecs[k].addr[11:0]});
      chk("vec_spm_rw", {31'b0, spm_rw}, {31'b0, vecs[k].rw});
      chk("vec_spm_wdata", spm_wr_data, vecs[k].wdata);
      chk("vec_busy", {31'b0, busy}, 32'd0);
      chk("vec_rd", rd_data, vecs[k].exp_rd);
      @(posedge clk); #1;
      chk("vec_no_req", {31'b0, bus_req_}, 32'd1);
    end
    as_ = 1'b1; flush = 1'b0; spm_rd_data = 32'h7777_7777;

    bus_txn(30'h0000_0100, 1'b1, 32'h0, 32'hCAFE_F00D, 2, 3, 0, 1'b0);
    bus_txn(30'h1000_0000, 1'b0, 32'h1234_5678, 32'h0BAD_0BAD, 0, 1, 4, 1'b0);
    bus_txn(30'h2000_0040, 1'b1, 32'h0, 32'hA5A5_5A5A, 1, 0, 2, 1'b1);
`ifndef SPM_BUS_IF_TIMEOUT_EN
    bus_txn(30'h3000_0000, 1'b1, 32'h0, 32'h1111_2222, 0, 10, 0, 1'b0);
`endif

    // Reset asserted in the middle of an access.
    addr = 30'h0000_0200; rw = 1'b1; as_ = 1'b0;
    @(posedge clk); #1;
    as_ = 1'b1; bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    bus_grnt_ = 1'b1;
    chk("mid_as_low", {31'b0, bus_as_}, 32'd0);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, bus_req_}, 32'd1);
    chk("mid_rst_as", {31'b0, bus_as_}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_addr", {2'b0, bus_addr}, 32'd0);
    exp_rd_buf = '0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_rd", rd_data, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_req", {31'b0, bus_req_}, 32'd1);
    bus_txn(30'h0000_0300, 1'b1, 32'h0, 32'h4444_5555, 1, 2, 1, 1'b0);

`ifdef SPM_BUS_IF_TIMEOUT_EN
    // Ready never arrives; the access aborts in its fifth ACCESS cycle.
    addr = 30'h0000_0400; rw = 1'b1; as_ = 1'b0;
    @(posedge clk); #1;
    as_ = 1'b1; bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    bus_grnt_ = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_busy", {31'b0, busy}, 32'd1);
      chk("to_err_low", {31'b0, bus_err}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_err_pulse", {31'b0, bus_err}, 32'd1);
    chk("to_busy_low", {31'b0, busy}, 32'd0);
    chk("to_rd", rd_data, 32'd0);
    @(posedge clk); #1;
    chk("to_req_high", {31'b0, bus_req_}, 32'd1);
    @(negedge clk);
    chk("to_err_gone", {31'b0, bus_err}, 32'd0);
    chk("to_idle_busy", {31'b0, busy}, 32'd0);
    chk("to_idle_rd", rd_data, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
